// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
//
// Purpose: state encoding, byte/word geometry and a helper that says which
//          states accept stream bytes.
// Ports:   none (package).
// Config:  IMEM_LOADER_CHECKSUM_EN enables the CSUM state in imem_loader.
package imem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int COUNT_W        = 16;

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      CSUM,
      DONE,
      ERR
   } state_t;

   // States in which the loader is willing to take a byte from the stream.
   function automatic logic accepts_bytes(input state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles little-endian bytes into one instruction word
//
// Purpose: collects BYTES_PER_WORD bytes, first byte in bits [7:0].
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      restart at byte index 0 (has priority over push)
//   push       accept byte_in this cycle
//   byte_in    incoming byte
//   word_out   assembled word; valid in the cycle full is high
//   full       pulse: this push completes a word
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          push,
   input  logic [7:0]                    byte_in,
   output logic [8*BYTES_PER_WORD-1:0]   word_out,
   output logic                          full
);

   localparam int IDX_W = $clog2(BYTES_PER_WORD);
   localparam int LOW_W = 8 * (BYTES_PER_WORD - 1);

   logic [IDX_W-1:0] idx;
   logic [LOW_W-1:0] low;

   // The last byte is not stored: it is combined with the earlier bytes on the
   // same cycle so the caller can register the complete word at that edge.
   assign full     = push && (idx == IDX_W'(BYTES_PER_WORD - 1));
   assign word_out = {byte_in, low};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
         low <= '0;
      end else if (clear) begin
         idx <= '0;
         low <= '0;
      end else if (push) begin
         idx <= full ? '0 : idx + 1'b1;
         // Shift right so earlier bytes end up in the lower lanes.
         low <= {byte_in, low[LOW_W-1:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader for the instruction memory write port
//
// Purpose: receives a 16-bit little-endian word count followed by little-endian
//          32-bit words, writes them to consecutive word addresses from 0 and
//          keeps the CPU held until the load completes.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   reload       one-cycle pulse, restarts the load from any state
//   in_data      stream byte; in_valid/in_ready handshake
//   mem_we       one-cycle write pulse; mem_addr / mem_wdata qualify it
//   cpu_hold     high except in DONE
//   done, error  completion / rejection levels, held until reload or rst
// Config:  `define IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte over
//          the length and data bytes, checked in the CSUM state.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              reload,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   // Word index must be able to reach the full capacity (2**ADDR_W).
   localparam int IDX_W = ADDR_W + 1;
   localparam logic [COUNT_W:0] MAX_WORDS = (COUNT_W+1)'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t FINAL_STATE = CSUM;
`else
   localparam state_t FINAL_STATE = DONE;
`endif

   state_t             state;
   state_t             state_next;
   logic [COUNT_W-1:0] count;
   logic [IDX_W-1:0]   word_idx;
   logic               xfer;
   logic               pk_push;
   logic               pk_full;
   logic [8*BYTES_PER_WORD-1:0] pk_word;
   logic [COUNT_W:0]   count_new;
   logic               last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         csum;
`endif

   assign xfer    = in_valid && in_ready;
   assign pk_push = xfer && (state == DATA) && !reload;

   // Full count as it will be once the high byte now on the bus is latched.
   assign count_new = {1'b0, in_data, count[7:0]};
   assign last_word = ((COUNT_W+1)'(word_idx) + (COUNT_W+1)'(1)) == {1'b0, count};

   byte_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .clear    (reload),
      .push     (pk_push),
      .byte_in  (in_data),
      .word_out (pk_word),
      .full     (pk_full)
   );

   always_comb begin
      state_next = state;
      case (state)
         LEN_LO: if (xfer) state_next = LEN_HI;
         LEN_HI: if (xfer) begin
            if (count_new == '0)
               state_next = FINAL_STATE;
            else if (count_new > MAX_WORDS)
               state_next = ERR;
            else
               state_next = DATA;
         end
         DATA:   if (pk_full) state_next = WRITE;
         WRITE:  state_next = last_word ? FINAL_STATE : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:   if (xfer) state_next = (in_data == csum) ? DONE : ERR;
`endif
         default: ;
      endcase
      // reload wins over anything, including a coincident transfer.
      if (reload)
         state_next = LEN_LO;
   end

   // All outputs are registered from the next state so they change together
   // with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= LEN_LO;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         count     <= '0;
         word_idx  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         state    <= state_next;
         in_ready <= accepts_bytes(state_next);
         cpu_hold <= (state_next != DONE);
         done     <= (state_next == DONE);
         error    <= (state_next == ERR);
         mem_we   <= pk_full;

         if (pk_full) begin
            mem_addr  <= word_idx[ADDR_W-1:0];
            mem_wdata <= DATA_W'(pk_word);
         end

         if (reload) begin
            count    <= '0;
            word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
         end else begin
            if (xfer && (state == LEN_LO))
               count[7:0] <= in_data;
            if (xfer && (state == LEN_HI))
               count[15:8] <= in_data;
            if (state == WRITE)
               word_idx <= word_idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (xfer && (state != CSUM))
               csum <= csum ^ in_data;
`endif
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int CAP    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              reload = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;

   int n_tests = 0;
   int n_fail  = 0;

   logic [ADDR_W+DATA_W-1:0] got_q[$];

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .reload    (reload),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   // Every cycle with mem_we high is one memory write.
   always @(negedge clk)
      if (mem_we === 1'b1)
         got_q.push_back({mem_addr, mem_wdata});

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   // Called at a negedge; holds the byte until it is taken at a posedge.
   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_timeout byte=%02h in_ready=%b required 1", b, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   // Reference: the stream is the count, then each word split LSB first; the
   // expected writes are (i, word i) for i = 0..count-1 unless count > capacity.
   task automatic run_load(input string name, input logic [15:0] cnt,
                           input logic [31:0] words_in[$],
                           input bit do_reload, input bit gaps);
      logic [7:0]  bytes[$];
      logic [31:0] words[$];
      logic [ADDR_W+DATA_W-1:0] exp_q[$];
      logic [ADDR_W+DATA_W-1:0] got;
      logic [ADDR_W+DATA_W-1:0] exp;
      logic [7:0]  x;
      bit          expect_err;
      int          n_words;
      words = words_in;
      if (do_reload) pulse_reload();
      got_q.delete();
      expect_err = (int'(cnt) > CAP);
      n_words    = expect_err ? 0 : int'(cnt);
      bytes.push_back(cnt[7:0]);
      bytes.push_back(cnt[15:8]);
      for (int i = 0; i < n_words; i++) begin
         if (i >= words.size()) words.push_back($urandom);
         for (int k = 0; k < 4; k++) bytes.push_back(8'(words[i] >> (8 * k)));
         exp_q.push_back({ADDR_W'(i), words[i]});
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!expect_err) begin
         x = 8'h00;
         foreach (bytes[j]) x = x ^ bytes[j];
         bytes.push_back(x);
      end
`endif
      foreach (bytes[j]) begin
         send_byte(bytes[j]);
         if (j >= 2 && j < 2 + 4 * n_words && ((j - 2) % 4) == 3) begin
            n_tests++;
            if (mem_we !== 1'b1 || in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL %s latency byte %0d: mem_we=%b in_ready=%b required 1/0",
                        name, j, mem_we, in_ready);
            end
         end
         if (gaps) idle($urandom_range(0, 2));
      end
      idle(3);
      n_tests++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL %s write_count got %0d required %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         got = got_q[i];
         exp = exp_q[i];
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s write[%0d] got addr=%0d data=%08h required addr=%0d data=%08h",
                     name, i, got[ADDR_W+DATA_W-1:DATA_W], got[DATA_W-1:0],
                     exp[ADDR_W+DATA_W-1:DATA_W], exp[DATA_W-1:0]);
         end
      end
      n_tests++;
      if (done !== !expect_err || error !== expect_err || cpu_hold !== expect_err
          || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s status done=%b error=%b cpu_hold=%b in_ready=%b required %b/%b/%b/0",
                  name, done, error, cpu_hold, in_ready, !expect_err, expect_err, expect_err);
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_tests++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0
          || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values rdy=%b we=%b addr=%0d wd=%08h hold=%b done=%b err=%b required 0/0/0/0/1/0/0",
                  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
      end
      idle(2);
      rst = 1'b0;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_ready got %b required 0", in_ready);
      end
      idle(1);
      n_tests++;
      if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL first_cycle_ready got rdy=%b hold=%b required 1/1", in_ready, cpu_hold);
      end
   endtask

   task automatic test_example();
      logic [31:0] w[$];
      w = '{32'h00000013, 32'h80000137};
      run_load("example", 16'd2, w, 1'b0, 1'b0);
   endtask

   task automatic test_zero_count();
      logic [31:0] w[$];
      run_load("zero_count", 16'd0, w, 1'b1, 1'b0);
   endtask

   task automatic test_too_big();
      logic [31:0] w[$];
      run_load("too_big", 16'h0401, w, 1'b1, 1'b0);
   endtask

   task automatic test_full_capacity();
      logic [31:0] w[$];
      run_load("full_capacity", 16'h0400, w, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] w[$];
      for (int r = 0; r < 6; r++)
         run_load($sformatf("random%0d", r), 16'($urandom_range(1, 12)), w, 1'b1, 1'b1);
   endtask

   task automatic test_reload();
      logic [31:0] w[$];
      pulse_reload();
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      // reload with a coincident transfer that must be ignored
      reload   = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(negedge clk);
      reload   = 1'b0;
      in_valid = 1'b0;
      n_tests++;
      if (error !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_mid_data err=%b done=%b hold=%b rdy=%b required 0/0/1/1",
                  error, done, cpu_hold, in_ready);
      end
      run_load("after_reload", 16'd3, w, 1'b0, 1'b0);
      run_load("err_before_reload", 16'hFFFF, w, 1'b1, 1'b0);
      pulse_reload();
      n_tests++;
      if (error !== 1'b0 || cpu_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_clears_error err=%b hold=%b required 0/1", error, cpu_hold);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] w[$];
      pulse_reload();
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL async_rst_data rdy=%b hold=%b done=%b we=%b required 0/1/0/0",
                  in_ready, cpu_hold, done, mem_we);
      end
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      run_load("after_rst", 16'd3, w, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (done !== 1'b0 || cpu_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL async_rst_done done=%b hold=%b required 0/1", done, cpu_hold);
      end
      @(negedge clk);
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] w[$];
      run_load("b2b_a", 16'd5, w, 1'b1, 1'b0);
      run_load("b2b_b", 16'd2, w, 1'b1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_example();
      test_zero_count();
      test_too_big();
      test_full_capacity();
      test_random();
      test_reload();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
